// File: rtl/fifo_word_serializer_pkg.sv
// Shared constants and state type for the 44-bit word FIFO read side and its serializer.
package fifo_word_serializer_pkg;

  localparam int WORD_W = 44;
  localparam int BEAT_W = 11;
  localparam int BEATS  = WORD_W / BEAT_W;
  localparam int BIDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

endpackage

// File: rtl/fifo_word_serializer.sv
// Pops words from the show-ahead FIFO and streams them out as BEATS narrow beats
// on a valid/ready interface, tagging the first and last beat of each word.
module fifo_word_serializer
  import fifo_word_serializer_pkg::*;
#(
  parameter int WORD_W    = fifo_word_serializer_pkg::WORD_W,
  parameter int BEAT_W    = fifo_word_serializer_pkg::BEAT_W,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rstp,
  input  logic [WORD_W-1:0] fifo_data,
  input  logic              fifo_empty,
  output logic              fifo_rd,
  output logic [BEAT_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_first,
  output logic              out_last,
  output logic              busy,
  output logic [CNT_W-1:0]  word_cnt
);

  localparam int BEATS = WORD_W / BEAT_W;
  localparam int BIDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BIDX_W-1:0] LAST_IDX = BIDX_W'(BEATS - 1);

  if (WORD_W % BEAT_W != 0) begin : g_bad_width
    $error("fifo_word_serializer: WORD_W must be a multiple of BEAT_W");
  end

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   shreg_q, shreg_d;
  logic [BIDX_W-1:0]   beat_idx_q, beat_idx_d;
  logic [CNT_W-1:0]    word_cnt_q;
  logic                out_valid_q, out_first_q, out_last_q;
  logic                accept, last_accept, pop;

  assign accept      = (state_q == SEND) && out_ready;
  assign last_accept = accept && (beat_idx_q == LAST_IDX);
  // The next word is popped on the last-beat accept so consecutive words have no bubble.
  assign pop         = !rstp && !fifo_empty && ((state_q == IDLE) || last_accept);

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    beat_idx_d = beat_idx_q;
    if (pop) begin
      state_d    = SEND;
      shreg_d    = fifo_data;
      beat_idx_d = '0;
    end else if (last_accept) begin
      state_d    = IDLE;
      shreg_d    = '0;
      beat_idx_d = '0;
    end else if (accept) begin
      shreg_d    = MSB_FIRST ? (shreg_q << BEAT_W) : (shreg_q >> BEAT_W);
      beat_idx_d = beat_idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rstp) begin
    if (rstp) shreg_q <= '0;
    else      shreg_q <= shreg_d;
  end

  always_ff @(posedge clk or posedge rstp) begin
    if (rstp) beat_idx_q <= '0;
    else      beat_idx_q <= beat_idx_d;
  end

  always_ff @(posedge clk or posedge rstp) begin
    if (rstp) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= (state_d == SEND);
      out_first_q <= (state_d == SEND) && (beat_idx_d == '0);
      out_last_q  <= (state_d == SEND) && (beat_idx_d == LAST_IDX);
    end
  end

  always_ff @(posedge clk or posedge rstp) begin
    if (rstp)             word_cnt_q <= '0;
    else if (last_accept) word_cnt_q <= word_cnt_q + 1'b1;
  end

  assign fifo_rd   = pop;
  assign out_data  = MSB_FIRST ? shreg_q[WORD_W-1 -: BEAT_W] : shreg_q[BEAT_W-1:0];
  assign out_valid = out_valid_q;
  assign out_first = out_first_q;
  assign out_last  = out_last_q;
  assign busy      = out_valid_q;
  assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Randomized bench for fifo_word_serializer with a queue-based FIFO and beat-slicing reference.
module tb_fifo_word_serializer;

  localparam int WORD_W    = 44;
  localparam int BEAT_W    = 11;
  localparam int BEATS     = 4;
  localparam int CNT_W     = 4;
  localparam bit MSB_FIRST = 1'b1;

  typedef struct packed {
    logic [BEAT_W-1:0] d;
    logic              f;
    logic              l;
  } beat_t;

  logic              clk = 1'b0;
  logic              rstp = 1'b1;
  logic [WORD_W-1:0] fifo_data = '0;
  logic              fifo_empty = 1'b1;
  logic              fifo_rd;
  logic [BEAT_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              out_first;
  logic              out_last;
  logic              busy;
  logic [CNT_W-1:0]  word_cnt;

  always #5 clk = ~clk;

  fifo_word_serializer #(
    .WORD_W(WORD_W), .BEAT_W(BEAT_W), .MSB_FIRST(MSB_FIRST), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rstp(rstp), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
    .fifo_rd(fifo_rd), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_first(out_first), .out_last(out_last), .busy(busy), .word_cnt(word_cnt)
  );

  int checks = 0;
  int errors = 0;

  logic [WORD_W-1:0] fq[$];
  beat_t             expq[$];
  beat_t             obsq[$];
  int                rd_cyc[$];
  int                cyc, valid_cnt, proto_err, stable_err, max_wcnt;
  logic              pv, pr, pf, pl;
  logic [BEAT_W-1:0] pd;

  function automatic beat_t model_beat(input logic [WORD_W-1:0] w, input int k);
    beat_t b;
    int sh;
    logic [WORD_W-1:0] t;
    sh = MSB_FIRST ? (BEATS - 1 - k) * BEAT_W : k * BEAT_W;
    t = w >> sh;
    b.d = t[BEAT_W-1:0];
    b.f = (k == 0);
    b.l = (k == BEATS - 1);
    return b;
  endfunction

  // One clock cycle: drive inputs after negedge, observe, then advance to next negedge.
  task automatic step(input bit rdy);
    logic [WORD_W-1:0] w;
    out_ready  = rdy;
    fifo_empty = (fq.size() == 0);
    fifo_data  = fifo_empty ? '0 : fq[0];
    #1;
    if (fifo_rd && fifo_empty) proto_err++;
    if (fifo_rd && out_valid && !(out_ready && out_last)) proto_err++;
    if (pv && !pr && (!out_valid || out_data !== pd || out_first !== pf || out_last !== pl))
      stable_err++;
    if (out_valid) valid_cnt++;
    if (int'(word_cnt) > max_wcnt) max_wcnt = int'(word_cnt);
    if (out_valid && out_ready) obsq.push_back('{out_data, out_first, out_last});
    if (fifo_rd && !fifo_empty) begin
      w = fq.pop_front();
      for (int k = 0; k < BEATS; k++) expq.push_back(model_beat(w, k));
      rd_cyc.push_back(cyc);
    end
    pv = out_valid; pr = out_ready; pd = out_data; pf = out_first; pl = out_last;
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_model();
    expq.delete(); obsq.delete(); rd_cyc.delete();
    cyc = 0; valid_cnt = 0; proto_err = 0; stable_err = 0; max_wcnt = 0;
    pv = 1'b0; pr = 1'b0; pd = '0; pf = 1'b0; pl = 1'b0;
  endtask

  task automatic do_reset();
    rstp = 1'b1;
    fq.delete();
    out_ready = 1'b0;
    fifo_empty = 1'b1;
    fifo_data = '0;
    clear_model();
    repeat (2) @(negedge clk);
    rstp = 1'b0;
  endtask

  task automatic run_beats(input int n, input bit rnd, input int bound, output bit timeout);
    int c = 0;
    while (obsq.size() < n && c < bound) begin
      step(rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      c++;
    end
    timeout = (obsq.size() < n);
  endtask

  task automatic test_reset();
    rstp = 1'b1;
    @(negedge clk);
    fifo_empty = 1'b0;
    fifo_data  = 44'h123_4567_89AB;
    out_ready  = 1'b1;
    #1;
    checks++; if (fifo_rd !== 1'b0) begin errors++; $display("FAIL reset_fifo_rd got=%b exp=0", fifo_rd); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", out_data); end
    checks++; if ({out_first, out_last, busy} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {out_first, out_last, busy}); end
    checks++; if (word_cnt !== '0) begin errors++; $display("FAIL reset_word_cnt got=%0d exp=0", word_cnt); end
    do_reset();
  endtask

  task automatic test_single();
    bit to;
    logic [BEAT_W-1:0] ref_d[4];
    ref_d[0] = 11'h55E; ref_d[1] = 11'h048; ref_d[2] = 11'h68A; ref_d[3] = 11'h678;
    do_reset();
    fq.push_back(44'hABC_1234_5678);
    run_beats(4, 1'b0, 20, to);
    repeat (3) step(1'b1);
    checks++; if (to) begin errors++; $display("FAIL single_timeout got=%0d beats exp=4", obsq.size()); end
    for (int i = 0; i < 4 && i < obsq.size(); i++) begin
      checks++;
      if (obsq[i] !== '{ref_d[i], (i == 0), (i == 3)}) begin
        errors++;
        $display("FAIL single_beat%0d got=%h f%b l%b exp=%h", i, obsq[i].d, obsq[i].f, obsq[i].l, ref_d[i]);
      end
    end
    checks++; if (word_cnt !== 4'd1) begin errors++; $display("FAIL single_word_cnt got=%0d exp=1", word_cnt); end
    checks++; if (rd_cyc.size() != 1) begin errors++; $display("FAIL single_rd_pulses got=%0d exp=1", rd_cyc.size()); end
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_idle_after got=%b%b exp=00", out_valid, busy); end
    checks++; if (proto_err != 0) begin errors++; $display("FAIL single_protocol got=%0d exp=0", proto_err); end
  endtask

  task automatic test_back_to_back();
    bit to;
    do_reset();
    repeat (3) fq.push_back({$urandom(), 12'($urandom())});
    run_beats(12, 1'b0, 40, to);
    checks++; if (to) begin errors++; $display("FAIL b2b_timeout got=%0d beats exp=12", obsq.size()); end
    checks++;
    if (rd_cyc.size() != 3 || rd_cyc[0] != 0 || rd_cyc[1] != 4 || rd_cyc[2] != 8) begin
      errors++;
      $display("FAIL b2b_rd_cycles got=%p exp=0,4,8", rd_cyc);
    end
    checks++; if (valid_cnt != 12 || cyc - 1 != 12) begin errors++; $display("FAIL b2b_no_bubble got=valid%0d last%0d exp=12,12", valid_cnt, cyc - 1); end
    for (int i = 0; i < 12 && i < obsq.size() && i < expq.size(); i++) begin
      checks++;
      if (obsq[i] !== expq[i]) begin errors++; $display("FAIL b2b_beat%0d got=%h exp=%h", i, obsq[i], expq[i]); end
    end
    checks++; if (word_cnt !== 4'd3) begin errors++; $display("FAIL b2b_word_cnt got=%0d exp=3", word_cnt); end
  endtask

  task automatic test_backpressure();
    bit to;
    logic [BEAT_W-1:0] ref_d[4];
    ref_d[0] = 11'h55E; ref_d[1] = 11'h048; ref_d[2] = 11'h68A; ref_d[3] = 11'h678;
    do_reset();
    fq.push_back(44'hABC_1234_5678);
    step(1'b1); step(1'b0); step(1'b0);
    run_beats(4, 1'b1, 300, to);
    checks++; if (to) begin errors++; $display("FAIL bp_timeout got=%0d beats exp=4", obsq.size()); end
    for (int i = 0; i < 4 && i < obsq.size(); i++) begin
      checks++;
      if (obsq[i] !== '{ref_d[i], (i == 0), (i == 3)}) begin
        errors++;
        $display("FAIL bp_beat%0d got=%h f%b l%b exp=%h", i, obsq[i].d, obsq[i].f, obsq[i].l, ref_d[i]);
      end
    end
    checks++; if (stable_err != 0) begin errors++; $display("FAIL bp_stable got=%0d exp=0", stable_err); end
    checks++; if (word_cnt !== 4'd1) begin errors++; $display("FAIL bp_word_cnt got=%0d exp=1", word_cnt); end
  endtask

  task automatic test_idle();
    int bad = 0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(1'($urandom_range(0, 1)));
      if (fifo_rd || out_valid || busy) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL idle_quiet got=%0d active cycles exp=0", bad); end
    fq.push_back({$urandom(), 12'($urandom())});
    step(1'b0);
    checks++; if (rd_cyc.size() != 1) begin errors++; $display("FAIL idle_pop got=%0d exp=1", rd_cyc.size()); end
    checks++;
    if (out_valid !== 1'b1 || out_first !== 1'b1 || busy !== 1'b1 || out_data !== expq[0].d) begin
      errors++;
      $display("FAIL idle_latency got=v%b f%b b%b d=%h exp=v1 f1 b1 d=%h", out_valid, out_first, busy, out_data, expq[0].d);
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    logic [WORD_W-1:0] w2;
    do_reset();
    w2 = {$urandom(), 12'($urandom())};
    fq.push_back({$urandom(), 12'($urandom())});
    fq.push_back(w2);
    run_beats(2, 1'b0, 20, to);
    checks++; if (to) begin errors++; $display("FAIL rmid_prep got=%0d beats exp=2", obsq.size()); end
    fifo_empty = 1'b0;
    fifo_data  = w2;
    #2 rstp = 1'b1;
    #1;
    checks++;
    if ({fifo_rd, out_valid, out_first, out_last, busy} !== 5'b0 || out_data !== '0 || word_cnt !== '0) begin
      errors++;
      $display("FAIL rmid_async got=rd%b v%b f%b l%b b%b d=%h c=%0d exp=all 0",
               fifo_rd, out_valid, out_first, out_last, busy, out_data, word_cnt);
    end
    @(negedge clk);
    rstp = 1'b0;
    clear_model();
    run_beats(4, 1'b0, 20, to);
    checks++; if (to) begin errors++; $display("FAIL rmid_timeout got=%0d beats exp=4", obsq.size()); end
    checks++;
    if (obsq.size() > 0 && obsq[0] !== model_beat(w2, 0)) begin
      errors++;
      $display("FAIL rmid_first got=%h exp=%h", obsq[0], model_beat(w2, 0));
    end
    for (int i = 1; i < 4 && i < obsq.size(); i++) begin
      checks++;
      if (obsq[i] !== model_beat(w2, i)) begin errors++; $display("FAIL rmid_beat%0d got=%h exp=%h", i, obsq[i], model_beat(w2, i)); end
    end
    checks++; if (word_cnt !== 4'd1) begin errors++; $display("FAIL rmid_word_cnt got=%0d exp=1", word_cnt); end
  endtask

  task automatic test_wrap();
    bit to;
    int bad = 0;
    do_reset();
    repeat (16) fq.push_back({$urandom(), 12'($urandom())});
    run_beats(64, 1'b1, 2000, to);
    checks++; if (to) begin errors++; $display("FAIL wrap_timeout got=%0d beats exp=64", obsq.size()); end
    for (int i = 0; i < obsq.size() && i < expq.size(); i++) if (obsq[i] !== expq[i]) bad++;
    checks++; if (bad != 0 || expq.size() != 64) begin errors++; $display("FAIL wrap_beats got=%0d bad of %0d exp=0 of 64", bad, expq.size()); end
    checks++; if (max_wcnt != 15) begin errors++; $display("FAIL wrap_max_cnt got=%0d exp=15", max_wcnt); end
    checks++; if (word_cnt !== 4'd0) begin errors++; $display("FAIL wrap_word_cnt got=%0d exp=0", word_cnt); end
    checks++; if (proto_err != 0 || stable_err != 0) begin errors++; $display("FAIL wrap_protocol got=%0d/%0d exp=0/0", proto_err, stable_err); end
  endtask

  initial begin
    clear_model();
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_idle();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
